full_st1_tap_ctrl: RTL
======================

FULL_ST1_TAP_CTRL -- requirements
Module: full_st1_tap_ctrl

Interface
REQ-001 SHALL have parameter LANES, 6, number of 32-bit tap lanes.
REQ-002 SHALL have parameter AW, 4, tap memory address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start / cfg_base / cfg_len / cfg_inter  input  1/AW/AW/1  read-sequence launch, first row, row count, interleave mode.
REQ-006 SHALL have port busy / done  output  1/1  sequence active, one-cycle completion pulse.
REQ-007 SHALL have port out_ready  input  1  downstream accepts read data.
REQ-008 SHALL have port rd_data_vld  output  1  tap memory read data valid.
REQ-009 SHALL have port ld_vld / ld_ready / ld_addr / ld_lane / ld_data  in/out/in/in/in  1/1/AW/3/32  host single-lane load.
REQ-010 SHALL have port up_vld / up_ready / up_addr  in/out/in  1/1/AW  full-row weight update request.
REQ-011 SHALL have port tap_rd_address / tap_rd_vld / tap_inter / tap_inter_first  output  AW/1/1/1  tap memory read controls.
REQ-012 SHALL have port tap_wr_address / tap_wr_vld / tap_sub_addr / tap_sub_vld / tap_sub_data  output  AW/1/3/1/32  tap memory write controls.

Function
REQ-013 SHALL implement FSM IDLE, FIRST, RUN, DRAIN.
REQ-014 SHALL, in IDLE on start with cfg_len != 0, latch cfg_base, cfg_len, cfg_inter and go to FIRST; start while not IDLE ignored.
REQ-015 SHALL, on start with cfg_len == 0, stay IDLE and pulse done next cycle with no read issued.
REQ-016 SHALL issue one read per cycle with out_ready high: FIRST asserts tap_rd_vld, tap_rd_address=base, tap_inter=tap_inter_first=latched cfg_inter; RUN asserts tap_rd_vld, tap_inter=cfg_inter, tap_inter_first=0.
REQ-017 SHALL increment read address mod 2^AW per issued read (wraps 15->0); row counter decrements; last read moves to DRAIN, otherwise FIRST->RUN.
REQ-018 SHALL, with out_ready low, drive tap_rd_vld=tap_inter=tap_inter_first=0 and hold address, counter and state (FIRST remains FIRST).
REQ-019 SHALL assert rd_data_vld exactly one cycle after each tap_rd_vld.
REQ-020 SHALL, in DRAIN, go IDLE after one cycle and pulse done coincident with the final rd_data_vld; busy=1 in FIRST/RUN/DRAIN.
REQ-021 SHALL grant at most one write per cycle: ld grant drives tap_sub_vld=1, tap_sub_addr=ld_lane, tap_sub_data=ld_data, tap_wr_address=ld_addr; up grant drives tap_wr_vld=1, tap_sub_vld=0, tap_wr_address=up_addr.
REQ-022 SHALL make ld_ready/up_ready combinational grants; transfer occurs when vld and ready both high.
REQ-023 SHALL block any write whose address equals the address being read in that cycle (ready low, requester stalls), no blocking when tap_rd_vld=0.
REQ-024 SHALL treat ld_lane >= LANES as a dropped write: ld_ready=1, tap_sub_vld=0, no memory update.

Reset
REQ-025 SHALL, on reset, force state IDLE, counters 0, arbitration pointer to ld, and all outputs 0 (busy, done, rd_data_vld, readies, all tap_* signals) immediately.
REQ-026 SHALL, on reset mid-sequence, abandon the sequence with no done pulse and no further reads.

Configuration
REQ-027 SHALL with TAP_CTRL_RR_EN defined arbitrate ld/up round-robin (pointer toggles on each granted write); without it, ld has fixed priority over up.

Verification
REQ-028 SHALL cover start, base=2, len=3, inter=0, out_ready=1 -> tap_rd_address 2,3,4 on consecutive cycles, rd_data_vld cycles 2-4, done with third rd_data_vld.
REQ-029 SHALL cover base=14, len=4, inter=1 -> addresses 14,15,0,1; tap_inter_first only on first read; tap_inter on all four.
REQ-030 SHALL cover out_ready low for 2 cycles after first read of len=3 -> no tap_rd_vld during stall, remaining reads resume in order, done one cycle after last.
REQ-031 SHALL cover simultaneous ld_vld and up_vld for 4 cycles -> with TAP_CTRL_RR_EN grants ld,up,ld,up; without, ld,ld,ld,ld.
REQ-032 SHALL cover up_addr=3 while sequence reads address 3 -> up_ready=0 that cycle, granted next cycle when read address is 4.
REQ-033 SHALL cover reset asserted during RUN of len=8 -> outputs 0 same cycle, no done, next start with len=1 runs normally.

Source files
------------

// File: rtl/full_st1_tap_ctrl.sv
// Tap memory controller: sequences row reads and arbitrates host lane loads and full-row updates.
// Latency: one read per cycle from FIRST; rd_data_vld one cycle after tap_rd_vld; done comes with the last data.
// Backpressure: out_ready low freezes the sequence; writes to the row being read stall. TAP_CTRL_RR_EN selects round-robin arbitration.
module full_st1_tap_ctrl #(
    parameter int LANES = 6,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_len,
    input  logic          cfg_inter,
    output logic          busy,
    output logic          done,
    input  logic          out_ready,
    output logic          rd_data_vld,
    input  logic          ld_vld,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [2:0]    ld_lane,
    input  logic [31:0]   ld_data,
    input  logic          up_vld,
    output logic          up_ready,
    input  logic [AW-1:0] up_addr,
    output logic [AW-1:0] tap_rd_address,
    output logic          tap_rd_vld,
    output logic          tap_inter,
    output logic          tap_inter_first,
    output logic [AW-1:0] tap_wr_address,
    output logic          tap_wr_vld,
    output logic [2:0]    tap_sub_addr,
    output logic          tap_sub_vld,
    output logic [31:0]   tap_sub_data
);

    typedef enum logic [1:0] {IDLE, FIRST, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    logic [AW-1:0] row_cnt, row_cnt_nxt;
    logic          inter_q, inter_nxt;
    logic          issue, last_issue, zero_start;
    logic          rd_data_vld_q, done_q;
    logic          ld_drop, ld_req, up_req, ld_gnt, up_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rd_addr       <= '0;
            row_cnt       <= '0;
            inter_q       <= 1'b0;
            rd_data_vld_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_nxt;
            rd_addr       <= rd_addr_nxt;
            row_cnt       <= row_cnt_nxt;
            inter_q       <= inter_nxt;
            rd_data_vld_q <= issue;
            done_q        <= last_issue | zero_start;
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        row_cnt_nxt = row_cnt;
        inter_nxt   = inter_q;
        issue       = 1'b0;
        last_issue  = 1'b0;
        zero_start  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        rd_addr_nxt = cfg_base;
                        row_cnt_nxt = cfg_len;
                        inter_nxt   = cfg_inter;
                        state_nxt   = FIRST;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            FIRST, RUN: begin
                if (out_ready) begin
                    issue       = 1'b1;
                    rd_addr_nxt = rd_addr + AW'(1);
                    row_cnt_nxt = row_cnt - AW'(1);
                    if (row_cnt == AW'(1)) begin
                        last_issue = 1'b1;
                        state_nxt  = DRAIN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writes never target the row being read this cycle; reset masks the combinational grants.
    always_comb begin
        ld_drop = !reset && ld_vld && (int'(ld_lane) >= LANES);
        ld_req  = !reset && ld_vld && !ld_drop && !(issue && ld_addr == rd_addr);
        up_req  = !reset && up_vld && !(issue && up_addr == rd_addr);
    end

`ifdef TAP_CTRL_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (ld_gnt || up_gnt) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_comb begin
        ld_gnt = ld_req && (!rr_ptr || !up_req);
        up_gnt = up_req && (rr_ptr || !ld_req);
    end
`else
    always_comb begin
        ld_gnt = ld_req;
        up_gnt = up_req && !ld_req;
    end
`endif

    always_comb begin
        busy            = (state != IDLE);
        done            = done_q;
        rd_data_vld     = rd_data_vld_q;
        tap_rd_vld      = issue;
        tap_rd_address  = issue ? rd_addr : '0;
        tap_inter       = issue && inter_q;
        tap_inter_first = issue && inter_q && (state == FIRST);
        ld_ready        = ld_gnt || ld_drop;
        up_ready        = up_gnt;
        tap_sub_vld     = ld_gnt;
        tap_sub_addr    = ld_gnt ? ld_lane : 3'd0;
        tap_sub_data    = ld_gnt ? ld_data : 32'd0;
        tap_wr_vld      = up_gnt;
        tap_wr_address  = '0;
        if (ld_gnt) begin
            tap_wr_address = ld_addr;
        end else if (up_gnt) begin
            tap_wr_address = up_addr;
        end
    end

endmodule
